// File: rtl/mau_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM encoding and access-size helpers.
// Also used by the CPU writeback path through mau_load_extend.
package mau_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b101;
  localparam logic [2:0] OP_BU = 3'b001;
  localparam logic [2:0] OP_H  = 3'b111;
  localparam logic [2:0] OP_HU = 3'b011;

  // Widest byte-enable any instance may need (XLEN up to 256).
  localparam int MAX_BE = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic       we;
    logic [2:0] op;
  } req_ctl_t;

  // op[0]=0 covers word plus the undefined codes, which all behave as a word.
  function automatic size_e op_size(input logic [2:0] op);
    if (!op[0]) return SZ_W;
    return op[1] ? SZ_H : SZ_B;
  endfunction

  function automatic logic [MAX_BE-1:0] size_mask(input logic [2:0] op);
    logic [MAX_BE-1:0] m;
    m = '0;
    case (op_size(op))
      SZ_B:    m[0]   = 1'b1;
      SZ_H:    m[1:0] = 2'b11;
      default: m      = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_if.sv
// CPU-side request/response and memory-side bus bundle for mem_access_unit.
// slave = the load/store unit itself; master = the CPU control and memory around it.
interface mau_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mau_load_extend.sv
// Combinational lane select plus sign/zero extension of a full memory word.
// Little-endian: the selected byte/half starts at byte lane lane_i.
module mau_load_extend
  import mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              word_i,
  input  logic [$clog2(XLEN/8)-1:0]    lane_i,
  input  logic [2:0]                   op_i,
  output logic [XLEN-1:0]              data_o
);

  logic [XLEN-1:0] shifted;
  logic            sgn;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    sgn     = 1'b0;
    data_o  = word_i;
    case (op_size(op_i))
      SZ_B: begin
        sgn    = op_i[2] & shifted[7];
        data_o = {{(XLEN-8){sgn}}, shifted[7:0]};
      end
      SZ_H: begin
        sgn    = op_i[2] & shifted[15];
        data_o = {{(XLEN-16){sgn}}, shifted[15:0]};
      end
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one request at a time, word-aligned byte-enabled bus,
// bounded wait for mem_ack, extended load data or err back to the CPU.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  mau_if.slave bus
);

  localparam int BE_W   = XLEN / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  req_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LANE_W-1:0] req_lane;
  logic [LANE_W-1:0] lane_q;
  logic              misaligned;
  logic [XLEN-1:0]   ext_data;
  logic [MAX_BE-1:0] mask_full;
  logic [BE_W-1:0]   be;
  logic [XLEN-1:0]   wdata_rep;
  logic              in_access;
  logic              in_resp;

  assign req_lane = bus.req_addr[LANE_W-1:0];
  assign lane_q   = addr_q[LANE_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (op_size(bus.req_op))
      SZ_H:    misaligned = req_lane[0];
      SZ_W:    misaligned = |req_lane;
      default: misaligned = 1'b0;
    endcase
  end

  mau_load_extend #(.XLEN(XLEN)) u_load_extend (
    .word_i (bus.mem_rdata),
    .lane_i (lane_q),
    .op_i   (ctl_q.op),
    .data_o (ext_data)
  );

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ctl_d   = '{we: bus.req_we, op: bus.req_op};
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = misaligned;
          // Misaligned requests never touch the bus.
          state_d = misaligned ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ack) begin
          rdata_d = ctl_q.we ? '0 : ext_data;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus lanes: size mask shifted to the addressed lane, store data replicated everywhere.
  always_comb begin
    mask_full = size_mask(ctl_q.op);
    be        = mask_full[BE_W-1:0] << lane_q;
    case (op_size(ctl_q.op))
      SZ_B:    wdata_rep = {BE_W{wdata_q[7:0]}};
      SZ_H:    wdata_rep = {(BE_W/2){wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  // All bus outputs derive from the async-reset state, so rst drops them without a clock.
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = in_resp;
  assign bus.resp_err   = in_resp & err_q;
  assign bus.resp_rdata = in_resp ? rdata_q : '0;

  assign bus.mem_req   = in_access;
  assign bus.mem_we    = in_access & ctl_q.we;
  assign bus.mem_addr  = in_access ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign bus.mem_be    = in_access ? be : '0;
  assign bus.mem_wdata = (in_access && ctl_q.we) ? wdata_rep : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a spec-level model sets per-cycle expectations,
// one negedge process compares every cycle, literal checks pin the model.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mau_if #(.XLEN(32), .ADDR_W(32)) bus ();

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // per-cycle expectations
  logic        e_rst = 1'b1;
  logic        e_ready = 1'b1, e_mem_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_rv = 1'b0, e_err = 1'b0;

  // observations for literal checks
  int          resp_count = 0, access_cycles = 0, resp_cyc = 0, accept_cyc = 0;
  logic [31:0] last_rdata = '0, last_wdata = '0, last_addr = '0;
  logic        last_err = 1'b0;
  logic [3:0]  last_be = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic int size_of(input logic [2:0] op);
    if (op == 3'b101 || op == 3'b001) return 1;
    if (op == 3'b111 || op == 3'b011) return 2;
    return 4;
  endfunction

  function automatic bit is_signed_op(input logic [2:0] op);
    return (op == 3'b101 || op == 3'b111);
  endfunction

  function automatic bit m_misaligned(input logic [2:0] op, input logic [31:0] addr);
    return (addr % size_of(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    int v;
    v = ((1 << size_of(op)) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * (addr % 4));
    if (size_of(op) == 1) begin
      v = v & 32'hFF;
      if (is_signed_op(op) && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size_of(op) == 2) begin
      v = v & 32'hFFFF;
      if (is_signed_op(op) && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
    if (size_of(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size_of(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic set_exp(input logic ready, input logic mreq, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                         input logic rv, input logic err, input logic [31:0] rd);
    e_ready = ready; e_mem_req = mreq; e_we = we; e_addr = addr; e_be = be;
    e_wdata = wd; e_rv = rv; e_err = err; e_rdata = rd;
  endtask

  task automatic set_idle();
    set_exp(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // ---- compare process ----
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("req_ready", bus.req_ready, e_ready);
    chk("mem_req", bus.mem_req, e_mem_req);
    chk("resp_valid", bus.resp_valid, e_rv);
    if (e_rst) begin
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
    end
    if (e_mem_req) begin
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_be", bus.mem_be, e_be);
      if (e_we) chk("mem_wdata", bus.mem_wdata & lane_mask(e_be), e_wdata & lane_mask(e_be));
    end
    if (e_rv) begin
      chk("resp_err", bus.resp_err, e_err);
      chk("resp_rdata", bus.resp_rdata, e_rdata);
    end
    if (bus.resp_valid === 1'b1) begin
      resp_count++; resp_cyc = cyc; last_rdata = bus.resp_rdata; last_err = bus.resp_err;
    end
    if (bus.mem_req === 1'b1) begin
      access_cycles++; last_be = bus.mem_be; last_wdata = bus.mem_wdata; last_addr = bus.mem_addr;
    end
  end

  // ---- stimulus ----
  int acc0, resp0;

  // waits: ACCESS cycles without ack before ack; >= TO means never acked.
  task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input int waits, input logic [31:0] rword);
    bit mis, done, err;
    logic [31:0] rexp;
    mis = m_misaligned(op, addr);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wdata;
    set_idle();
    accept_cyc = cyc; acc0 = access_cycles; resp0 = resp_count;
    @(posedge clk); #1;
    // A different request held on the port must be ignored while busy.
    bus.req_we = ~we; bus.req_op = ~op; bus.req_addr = ~addr; bus.req_wdata = ~wdata;
    err = mis; rexp = '0;
    if (!mis) begin
      done = 0;
      for (int k = 0; !done && k < 64; k++) begin
        set_exp(1'b0, 1'b1, we, addr & 32'hFFFF_FFFC, m_be(op, addr),
                m_wdata(op, wdata), 1'b0, 1'b0, '0);
        bus.mem_ack   = (k == waits);
        bus.mem_rdata = (k == waits) ? rword : $urandom;
        if (k == waits) begin
          done = 1; rexp = we ? 32'h0 : m_load(op, addr, rword);
        end else if (k == TO - 1) begin
          done = 1; err = 1;
        end
        @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    end
    bus.req_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, err, rexp);
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = OP_W;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_mem_req", bus.mem_req, 0);
    rst = 1'b0; e_rst = 1'b0;

    // 1: lw, zero-wait
    txn(1'b0, OP_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("t1_be", last_be, 4'b1111);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_latency", resp_cyc - accept_cyc, 2);
    chk("t1_resp_cnt", resp_count - resp0, 1);

    // 2: lb / lbu at lane 3
    txn(1'b0, OP_B, 32'h103, 32'h0, 0, 32'h80FF7F01);
    chk("t2_be", last_be, 4'b1000);
    chk("t2_lb", last_rdata, 32'hFFFFFF80);
    txn(1'b0, OP_BU, 32'h103, 32'h0, 1, 32'h80FF7F01);
    chk("t2_lbu", last_rdata, 32'h00000080);

    // 3: lh at lane 2, misaligned lhu
    txn(1'b0, OP_H, 32'h102, 32'h0, 0, 32'h80011234);
    chk("t3_lh", last_rdata, 32'hFFFF8001);
    txn(1'b0, OP_HU, 32'h101, 32'h0, 0, 32'h0);
    chk("t3_mis_err", last_err, 1);
    chk("t3_mis_no_bus", access_cycles - acc0, 0);
    chk("t3_mis_latency", resp_cyc - accept_cyc, 1);

    // 4: sh with 3 waits
    txn(1'b1, OP_H, 32'h202, 32'h0000ABCD, 3, 32'h0);
    chk("t4_be", last_be, 4'b1100);
    chk("t4_wdata", last_wdata, 32'hABCDABCD);
    chk("t4_addr", last_addr, 32'h200);
    chk("t4_hold", access_cycles - acc0, 4);
    chk("t4_rdata", last_rdata, 0);

    // 5: timeout, then ack on the last allowed cycle
    txn(1'b0, OP_W, 32'h400, 32'h0, 1000, 32'h0);
    chk("t5_to_err", last_err, 1);
    chk("t5_to_cycles", access_cycles - acc0, 15);
    txn(1'b0, OP_W, 32'h404, 32'h0, 14, 32'h13579BDF);
    chk("t5_last_ack_err", last_err, 0);
    chk("t5_last_ack_cycles", access_cycles - acc0, 15);
    chk("t5_last_ack_rdata", last_rdata, 32'h13579BDF);

    // extra directed cases
    txn(1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h12345678);
    chk("undef_op_word", last_rdata, 32'h12345678);
    txn(1'b0, OP_W, 32'h102, 32'h0, 0, 32'h0);
    chk("lw_mis_err", last_err, 1);
    txn(1'b1, OP_B, 32'h205, 32'h0000005A, 0, 32'h0);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    txn(1'b0, OP_HU, 32'h102, 32'h0, 0, 32'hF00D1234);
    chk("lhu_rdata", last_rdata, 32'h0000F00D);
    txn(1'b0, OP_B, 32'h101, 32'h0, 0, 32'h00007F00);
    chk("lb_pos", last_rdata, 32'h0000007F);

    // 6: async reset mid-ACCESS
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = OP_W; bus.req_addr = 32'h300;
    set_idle();
    resp0 = resp_count;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 32'h300, 4'b1111, '0, 1'b0, 1'b0, '0);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1; e_rst = 1'b1; set_idle();
    #1;
    chk("t6_async_mem_req", bus.mem_req, 0);
    chk("t6_async_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; e_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_resp", resp_count - resp0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
